// File: rtl/axi_rd_arbiter.sv
// Two-master AXI-Lite read arbiter (fetch = m0, LSU = m1) in front of one slave read port.
// One transaction in flight at a time; ties are broken round-robin.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_ar_valid_i,
    input  logic [ADDR_W-1:0] m0_ar_addr_i,
    output logic              m0_ar_ready_o,
    output logic              m0_r_valid_o,
    output logic [DATA_W-1:0] m0_r_data_o,
    output logic [1:0]        m0_r_resp_o,
    input  logic              m0_r_ready_i,
    input  logic              m1_ar_valid_i,
    input  logic [ADDR_W-1:0] m1_ar_addr_i,
    output logic              m1_ar_ready_o,
    output logic              m1_r_valid_o,
    output logic [DATA_W-1:0] m1_r_data_o,
    output logic [1:0]        m1_r_resp_o,
    input  logic              m1_r_ready_i,
    output logic              s_ar_valid_o,
    output logic [ADDR_W-1:0] s_ar_addr_o,
    input  logic              s_ar_ready_i,
    input  logic              s_r_valid_i,
    input  logic [DATA_W-1:0] s_r_data_i,
    input  logic [1:0]        s_r_resp_i,
    output logic              s_r_ready_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_ADDR = 3'b010,
        S_DATA = 3'b100
    } state_t;

    state_t            r_state;
    logic              r_grant;   // 0 = m0 owns the transaction, 1 = m1
    logic              r_last;    // master served most recently
    logic [ADDR_W-1:0] r_addr;

    logic w_idle, w_data, w_req, w_pick1, w_g0, w_g1;

    assign w_idle  = (r_state == S_IDLE);
    assign w_data  = (r_state == S_DATA);
    assign w_req   = m0_ar_valid_i | m1_ar_valid_i;
    // m1 wins when alone, or on a tie when m0 was served last
    assign w_pick1 = m1_ar_valid_i & (~m0_ar_valid_i | ~r_last);
    assign w_g0    = w_data & ~r_grant;
    assign w_g1    = w_data & r_grant;

    // A handshake during reset would be discarded, so never advertise one
    assign m0_ar_ready_o = w_idle & ~rst_i & m0_ar_valid_i & ~w_pick1;
    assign m1_ar_ready_o = w_idle & ~rst_i & w_pick1;

    assign s_ar_valid_o = (r_state == S_ADDR);
    assign s_ar_addr_o  = r_addr;

    assign s_r_ready_o  = (w_g0 & m0_r_ready_i) | (w_g1 & m1_r_ready_i);

    assign m0_r_valid_o = w_g0 & s_r_valid_i;
    assign m0_r_data_o  = w_g0 ? s_r_data_i : '0;
    assign m0_r_resp_o  = w_g0 ? s_r_resp_i : 2'b00;
    assign m1_r_valid_o = w_g1 & s_r_valid_i;
    assign m1_r_data_o  = w_g1 ? s_r_data_i : '0;
    assign m1_r_resp_o  = w_g1 ? s_r_resp_i : 2'b00;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_req) begin
                    r_grant <= w_pick1;
                    r_addr  <= w_pick1 ? m1_ar_addr_i : m0_ar_addr_i;
                    r_state <= S_ADDR;
                end
                S_ADDR: if (s_ar_ready_i) r_state <= S_DATA;
                S_DATA: if (s_r_valid_i && s_r_ready_o) begin
                    r_last  <= r_grant;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: transaction-level model of masters, arbiter and slave.
module tb_axi_rd_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          m0_ar_valid_i, m0_ar_ready_o, m0_r_valid_o, m0_r_ready_i;
    logic [AW-1:0] m0_ar_addr_i;
    logic [DW-1:0] m0_r_data_o;
    logic [1:0]    m0_r_resp_o;
    logic          m1_ar_valid_i, m1_ar_ready_o, m1_r_valid_o, m1_r_ready_i;
    logic [AW-1:0] m1_ar_addr_i;
    logic [DW-1:0] m1_r_data_o;
    logic [1:0]    m1_r_resp_o;
    logic          s_ar_valid_o, s_ar_ready_i, s_r_valid_i, s_r_ready_o;
    logic [AW-1:0] s_ar_addr_o;
    logic [DW-1:0] s_r_data_i;
    logic [1:0]    s_r_resp_i;

    always #5 clk_i = ~clk_i;

    axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_ar_valid_i(m0_ar_valid_i), .m0_ar_addr_i(m0_ar_addr_i), .m0_ar_ready_o(m0_ar_ready_o),
        .m0_r_valid_o(m0_r_valid_o), .m0_r_data_o(m0_r_data_o), .m0_r_resp_o(m0_r_resp_o),
        .m0_r_ready_i(m0_r_ready_i),
        .m1_ar_valid_i(m1_ar_valid_i), .m1_ar_addr_i(m1_ar_addr_i), .m1_ar_ready_o(m1_ar_ready_o),
        .m1_r_valid_o(m1_r_valid_o), .m1_r_data_o(m1_r_data_o), .m1_r_resp_o(m1_r_resp_o),
        .m1_r_ready_i(m1_r_ready_i),
        .s_ar_valid_o(s_ar_valid_o), .s_ar_addr_o(s_ar_addr_o), .s_ar_ready_i(s_ar_ready_i),
        .s_r_valid_i(s_r_valid_i), .s_r_data_i(s_r_data_i), .s_r_resp_i(s_r_resp_i),
        .s_r_ready_o(s_r_ready_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: who is in flight, which phase, who was served last
    bit            busy, adone;
    int            owner, last;
    logic [AW-1:0] exp_addr;
    bit            req_v [2];
    logic [AW-1:0] req_a [2];
    bit            force_tie;
    // Slave model
    bit            sl_pend;
    int            sl_cnt;
    logic [DW-1:0] sl_data;
    logic [1:0]    sl_resp;
    int            n_done;
    int            resp_seen [4];

    task automatic model_reset();
        busy = 0; adone = 0; owner = 0; last = 1; sl_pend = 0;
        for (int i = 0; i < 2; i++) req_v[i] = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++)
            if (!req_v[i] && (force_tie || $urandom_range(0, 1) == 1)) begin
                req_v[i] = 1;
                req_a[i] = $urandom;
            end
        force_tie = 0;
        m0_ar_valid_i = req_v[0]; m0_ar_addr_i = req_a[0];
        m1_ar_valid_i = req_v[1]; m1_ar_addr_i = req_a[1];
        m0_r_ready_i  = ($urandom_range(0, 3) != 0);
        m1_r_ready_i  = ($urandom_range(0, 3) != 0);
        s_ar_ready_i  = ($urandom_range(0, 2) != 0);
        s_r_valid_i   = 0;
        s_r_data_i    = $urandom;
        s_r_resp_i    = 2'($urandom_range(0, 3));
        if (sl_pend) begin
            if (sl_cnt == 0) begin
                s_r_valid_i = 1; s_r_data_i = sl_data; s_r_resp_i = sl_resp;
            end else sl_cnt--;
        end else begin
            // stray beat while nothing is outstanding must be ignored
            s_r_valid_i = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_m0_arr"}, m0_ar_ready_o, 0);
        chk({tag, "_m1_arr"}, m1_ar_ready_o, 0);
        chk({tag, "_s_arv"},  s_ar_valid_o, 0);
        chk({tag, "_s_ara"},  s_ar_addr_o, 0);
        chk({tag, "_s_rr"},   s_r_ready_o, 0);
        chk({tag, "_m0_rv"},  m0_r_valid_o, 0);
        chk({tag, "_m1_rv"},  m1_r_valid_o, 0);
        chk({tag, "_m0_rd"},  {m0_r_data_o, m0_r_resp_o}, 0);
        chk({tag, "_m1_rd"},  {m1_r_data_o, m1_r_resp_o}, 0);
    endtask

    // Check one cycle's outputs against the model, then advance the model past the coming edge
    task automatic step();
        int  win;
        bit  dph, exp_rr;
        #1;
        win = -1;
        if (!busy) begin
            if (req_v[0] && req_v[1]) win = (last == 1) ? 0 : 1;
            else if (req_v[0])        win = 0;
            else if (req_v[1])        win = 1;
        end
        chk("m0_ar_ready", m0_ar_ready_o, win == 0);
        chk("m1_ar_ready", m1_ar_ready_o, win == 1);
        chk("s_ar_valid", s_ar_valid_o, busy && !adone);
        if (busy && !adone) chk("s_ar_addr", s_ar_addr_o, exp_addr);
        dph    = busy && adone;
        exp_rr = dph && ((owner == 0) ? m0_r_ready_i : m1_r_ready_i);
        chk("s_r_ready", s_r_ready_o, exp_rr);
        chk("m0_r_valid", m0_r_valid_o, dph && owner == 0 && s_r_valid_i);
        chk("m1_r_valid", m1_r_valid_o, dph && owner == 1 && s_r_valid_i);
        chk("m0_r_data", {m0_r_data_o, m0_r_resp_o},
            (dph && owner == 0) ? {s_r_data_i, s_r_resp_i} : '0);
        chk("m1_r_data", {m1_r_data_o, m1_r_resp_o},
            (dph && owner == 1) ? {s_r_data_i, s_r_resp_i} : '0);

        if (dph && s_r_valid_i && exp_rr) begin
            busy = 0; last = owner; sl_pend = 0; n_done++;
            resp_seen[s_r_resp_i]++;
        end else if (busy && !adone && s_ar_ready_i) begin
            adone = 1; sl_pend = 1;
            sl_cnt  = $urandom_range(0, 3);
            sl_data = $urandom;
            sl_resp = 2'($urandom_range(0, 3));
        end
        if (win >= 0) begin
            busy = 1; adone = 0; owner = win; exp_addr = req_a[win];
            req_v[win] = 0;
        end
    endtask

    initial begin
        bit did_rst;
        rst_i = 1;
        m0_ar_valid_i = 0; m0_ar_addr_i = '0; m0_r_ready_i = 0;
        m1_ar_valid_i = 0; m1_ar_addr_i = '0; m1_r_ready_i = 0;
        s_ar_ready_i = 0; s_r_valid_i = 0; s_r_data_i = '0; s_r_resp_i = '0;
        model_reset();
        force_tie = 1;
        n_done = 0; did_rst = 0;
        for (int i = 0; i < 4; i++) resp_seen[i] = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 0;
        #1 check_all_zero("reset");

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_i);
            if (!did_rst && cyc > 1200 && busy && adone) begin
                // reset in the data phase: beat dropped, back to idle, last reverts to m1
                did_rst = 1;
                drive();
                m0_ar_valid_i = 0; m1_ar_valid_i = 0;
                s_r_valid_i = 1;
                rst_i = 1;
                #1;
                chk("rst_m0_arr", m0_ar_ready_o, 0);
                chk("rst_m1_arr", m1_ar_ready_o, 0);
                model_reset();
                @(negedge clk_i);
                rst_i = 0;
                m0_ar_valid_i = 0; m1_ar_valid_i = 0;
                s_ar_ready_i = 1; s_r_valid_i = 1; s_r_data_i = 32'hDEAD_BEEF; s_r_resp_i = 2'b10;
                m0_r_ready_i = 1; m1_r_ready_i = 1;
                #1 check_all_zero("post_rst");
                @(negedge clk_i);
                force_tie = 1;
                drive();
                step();
                chk("tie_after_rst_m0", m0_ar_ready_o, 1);
            end else begin
                drive();
                step();
            end
        end

        chk("did_mid_reset", did_rst, 1);
        chk("progress", n_done >= 200, 1);
        chk("slverr_seen", resp_seen[2] > 0, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
